// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states and the
// latched request record.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        SIZE_B    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_W    = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        mem_size_t         size;
        logic              is_unsigned;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational RISC-V sub-word formatting: store lane replication, byte
// enables, misalignment detection and load lane extract with sign/zero extend.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  mem_size_t         size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              misaligned,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    // Replicating the store data means the addressed lanes always carry it,
    // so only the byte enables depend on the low address bits.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        lane_wdata = '0;
        load_data  = '0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {(is_unsigned ? 24'h0 : {24{shifted[7]}}), shifted[7:0]};
            end
            SIZE_H: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << addr_lo;
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {(is_unsigned ? 16'h0 : {16{shifted[15]}}), shifted[15:0]};
            end
            SIZE_W: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                lane_wdata = store_data;
                load_data  = shifted;
            end
            SIZE_RSVD: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of a byte-enabled
// data memory with combinational read; one access per three cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic                  p0_req_we,
    input  logic [1:0]            p0_req_size,
    input  logic                  p0_req_unsigned,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic                  p1_req_we,
    input  logic [1:0]            p1_req_size,
    input  logic                  p1_req_unsigned,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  owner;
    logic                  grant;
    logic                  accept;
    req_t                  p0_req;
    req_t                  p1_req;
    req_t                  grant_req;
    req_t                  cur_req;
    req_t                  align_req;
    logic                  align_err;
    logic [3:0]            align_be;
    logic [DATA_W-1:0]     align_wdata;
    logic [DATA_W-1:0]     align_load;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    always_comb begin
        p0_req.addr        = p0_req_addr;
        p0_req.we          = p0_req_we;
        p0_req.size        = mem_size_t'(p0_req_size);
        p0_req.is_unsigned = p0_req_unsigned;
        p0_req.wdata       = p0_req_wdata;
        p1_req.addr        = p1_req_addr;
        p1_req.we          = p1_req_we;
        p1_req.size        = mem_size_t'(p1_req_size);
        p1_req.is_unsigned = p1_req_unsigned;
        p1_req.wdata       = p1_req_wdata;
    end

    // On a tie the port that did not win last time is served.
    assign grant        = (p0_req_valid && p1_req_valid) ? ~last_grant : p1_req_valid;
    assign grant_req    = grant ? p1_req : p0_req;
    assign accept       = (state == IDLE) && (p0_req_valid || p1_req_valid);
    assign p0_req_ready = accept && !grant;
    assign p1_req_ready = accept && grant;

    // One aligner serves both phases: it formats the incoming winner so the
    // memory strobes can be registered at the handshake, then extracts load
    // data for the latched request during ACCESS.
    assign align_req = (state == IDLE) ? grant_req : cur_req;

    lsu_align u_align (
        .addr_lo     (align_req.addr[1:0]),
        .size        (align_req.size),
        .is_unsigned (align_req.is_unsigned),
        .store_data  (align_req.wdata),
        .mem_rdata   (mem_rdata),
        .misaligned  (align_err),
        .be          (align_be),
        .lane_wdata  (align_wdata),
        .load_data   (align_load)
    );

    assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata_q : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata_q : '0;
    assign p0_rsp_err   = p0_rsp_valid && rsp_err_q;
    assign p1_rsp_err   = p1_rsp_valid && rsp_err_q;

    // Clearing the memory strobes asynchronously keeps a store caught by reset
    // in ACCESS from committing at the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cur_req      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= 4'b0000;
            mem_we       <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_req    <= align_req;
                        owner      <= grant;
                        last_grant <= grant;
                        mem_addr   <= {align_req.addr[ADDR_W-1:2], 2'b00};
                        mem_we     <= align_req.we && !align_err;
                        mem_be     <= (align_req.we && !align_err) ? align_be : 4'b0000;
                        mem_wdata  <= (align_req.we && !align_err) ? align_wdata : '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                    mem_be       <= 4'b0000;
                    mem_we       <= 1'b0;
                    rsp_rdata_q  <= (cur_req.we || align_err) ? '0 : align_load;
                    rsp_err_q    <= align_err;
                    p0_rsp_valid <= !owner;
                    p1_rsp_valid <= owner;
                    state        <= RESP;
                end
                RESP: begin
                    p0_rsp_valid <= 1'b0;
                    p1_rsp_valid <= 1'b0;
                    rsp_rdata_q  <= '0;
                    rsp_err_q    <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory behind it
// and hand-computed expected values.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic [1:0]  p0_req_size;
    logic        p0_rsp_valid, p0_rsp_err;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [1:0]  p1_req_size;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we;

    logic [31:0] mem [0:255];

    int passCount;
    int checkCount;

    logic        acc_we, acc_ready;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr, acc_wdata;
    logic        rsp_own, rsp_other, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .p0_req_valid    (p0_req_valid),
        .p0_req_ready    (p0_req_ready),
        .p0_req_addr     (p0_req_addr),
        .p0_req_we       (p0_req_we),
        .p0_req_size     (p0_req_size),
        .p0_req_unsigned (p0_req_unsigned),
        .p0_req_wdata    (p0_req_wdata),
        .p0_rsp_valid    (p0_rsp_valid),
        .p0_rsp_rdata    (p0_rsp_rdata),
        .p0_rsp_err      (p0_rsp_err),
        .p1_req_valid    (p1_req_valid),
        .p1_req_ready    (p1_req_ready),
        .p1_req_addr     (p1_req_addr),
        .p1_req_we       (p1_req_we),
        .p1_req_size     (p1_req_size),
        .p1_req_unsigned (p1_req_unsigned),
        .p1_req_wdata    (p1_req_wdata),
        .p1_rsp_valid    (p1_rsp_valid),
        .p1_rsp_rdata    (p1_rsp_rdata),
        .p1_rsp_err      (p1_rsp_err),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        else
            passCount++;
    endtask

    // Issues one request, records the memory strobes seen in ACCESS and the
    // response seen two cycles after the handshake.
    task automatic applyStimulus(input bit port, input logic [31:0] addr, input logic we,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        int waited;
        @(negedge clk);
        if (port == 1'b0) begin
            p0_req_valid = 1'b1; p0_req_addr = addr; p0_req_we = we;
            p0_req_size = size; p0_req_unsigned = uns; p0_req_wdata = wdata;
        end else begin
            p1_req_valid = 1'b1; p1_req_addr = addr; p1_req_we = we;
            p1_req_size = size; p1_req_unsigned = uns; p1_req_wdata = wdata;
        end
        waited = 0;
        #1;
        while (!(port ? p1_req_ready : p0_req_ready) && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("accept_within_bound", 32'(waited < 10), 32'd1);
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        acc_we    = mem_we;
        acc_be    = mem_be;
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        acc_ready = p0_req_ready | p1_req_ready;
        @(posedge clk);
        #1;
        rsp_own   = port ? p1_rsp_valid : p0_rsp_valid;
        rsp_other = port ? p0_rsp_valid : p1_rsp_valid;
        rsp_rdata = port ? p1_rsp_rdata : p0_rsp_rdata;
        rsp_err   = port ? p1_rsp_err   : p0_rsp_err;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rspSeen;
        logic [3:0] flags, expFlags;
        passCount  = 0;
        checkCount = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        p0_req_valid = 1'b0; p0_req_addr = '0; p0_req_we = 1'b0;
        p0_req_size = 2'b00; p0_req_unsigned = 1'b0; p0_req_wdata = '0;
        p1_req_valid = 1'b0; p1_req_addr = '0; p1_req_we = 1'b0;
        p1_req_size = 2'b00; p1_req_unsigned = 1'b0; p1_req_wdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_p0_ready", 32'(p0_req_ready), 32'd0);
        checkOutput("reset_rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        applyStimulus(1'b0, 32'h100, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
        checkOutput("sw_we", 32'(acc_we), 32'd1);
        checkOutput("sw_be", 32'(acc_be), 32'hF);
        checkOutput("sw_addr", acc_addr, 32'h100);
        checkOutput("sw_wdata", acc_wdata, 32'hDEADBEEF);
        checkOutput("sw_ready_in_access", 32'(acc_ready), 32'd0);
        checkOutput("sw_rsp_valid", {30'd0, rsp_own, rsp_other}, 32'b10);
        checkOutput("sw_rsp_rdata", rsp_rdata, 32'h0);

        applyStimulus(1'b0, 32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        checkOutput("lw_we_be", {27'd0, acc_we, acc_be}, 32'h0);
        checkOutput("lw_rsp_valid", 32'(rsp_own), 32'd1);
        checkOutput("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        checkOutput("lw_err", 32'(rsp_err), 32'd0);

        applyStimulus(1'b0, 32'h103, 1'b1, 2'b00, 1'b0, 32'h80);
        checkOutput("sb_be", 32'(acc_be), 32'b1000);
        checkOutput("sb_wdata", acc_wdata, 32'h80808080);
        applyStimulus(1'b0, 32'h103, 1'b0, 2'b00, 1'b0, 32'h0);
        checkOutput("lb_signed", rsp_rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h103, 1'b0, 2'b00, 1'b1, 32'h0);
        checkOutput("lbu", rsp_rdata, 32'h00000080);
        applyStimulus(1'b1, 32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        checkOutput("lw_after_sb_p1", rsp_rdata, 32'h80ADBEEF);
        checkOutput("lw_p1_owner_only", {30'd0, rsp_own, rsp_other}, 32'b10);

        applyStimulus(1'b0, 32'h202, 1'b1, 2'b01, 1'b0, 32'h0000ABCD);
        checkOutput("sh_be", 32'(acc_be), 32'b1100);
        checkOutput("sh_mem_word", mem[8'h80], 32'hABCD0000);
        applyStimulus(1'b0, 32'h202, 1'b0, 2'b01, 1'b0, 32'h0);
        checkOutput("lh_signed", rsp_rdata, 32'hFFFFABCD);
        applyStimulus(1'b0, 32'h202, 1'b0, 2'b01, 1'b1, 32'h0);
        checkOutput("lhu", rsp_rdata, 32'h0000ABCD);

        applyStimulus(1'b0, 32'h101, 1'b0, 2'b10, 1'b0, 32'h0);
        checkOutput("lw_mis_err", 32'(rsp_err), 32'd1);
        checkOutput("lw_mis_rdata", rsp_rdata, 32'h0);
        applyStimulus(1'b0, 32'h103, 1'b1, 2'b01, 1'b0, 32'h1234);
        checkOutput("sh_mis_we_be", {27'd0, acc_we, acc_be}, 32'h0);
        checkOutput("sh_mis_err", 32'(rsp_err), 32'd1);
        checkOutput("sh_mis_mem", mem[8'h40], 32'h80ADBEEF);
        applyStimulus(1'b1, 32'h100, 1'b0, 2'b11, 1'b0, 32'h0);
        checkOutput("rsvd_size_err", 32'(rsp_err), 32'd1);
        checkOutput("rsvd_size_rdata", rsp_rdata, 32'h0);

        // Fairness from reset: p0 wins the first tie, then strict alternation.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p0_req_valid = 1'b1; p0_req_addr = 32'h100; p0_req_we = 1'b0;
        p0_req_size = 2'b10; p0_req_unsigned = 1'b0;
        p1_req_valid = 1'b1; p1_req_addr = 32'h200; p1_req_we = 1'b0;
        p1_req_size = 2'b10; p1_req_unsigned = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            flags = {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid};
            case (c % 6)
                0:       expFlags = 4'b1000;
                2:       expFlags = 4'b0010;
                3:       expFlags = 4'b0100;
                5:       expFlags = 4'b0001;
                default: expFlags = 4'b0000;
            endcase
            checkOutput($sformatf("fair_cycle%0d", c), 32'(flags), 32'(expFlags));
            if (c == 2) checkOutput("fair_p0_rdata", p0_rsp_rdata, 32'h80ADBEEF);
            if (c == 5) checkOutput("fair_p1_rdata", p1_rsp_rdata, 32'hABCD0000);
            @(negedge clk);
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;

        // Reset during ACCESS of a store must drop it without a response.
        applyStimulus(1'b0, 32'h300, 1'b1, 2'b10, 1'b0, 32'h0BADF00D);
        @(negedge clk);
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_addr = 32'h300; p0_req_we = 1'b1;
        p0_req_size = 2'b10; p0_req_unsigned = 1'b0; p0_req_wdata = 32'h12345678;
        #1;
        checkOutput("rst_store_ready", 32'(p0_req_ready), 32'd1);
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        checkOutput("rst_store_access_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_clear", {mem_addr[27:0], mem_we, mem_be[2:0]}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        rspSeen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (p0_rsp_valid || p1_rsp_valid) rspSeen++;
        end
        checkOutput("rst_no_response", 32'(rspSeen), 32'd0);
        checkOutput("rst_mem_unchanged", mem[8'hC0], 32'h0BADF00D);
        applyStimulus(1'b0, 32'h300, 1'b0, 2'b10, 1'b0, 32'h0);
        checkOutput("rst_load_prior", rsp_rdata, 32'h0BADF00D);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-lane data memory. It shares one data memory between requester 0 (CPU load/store path) and requester 1 (DMA/debug loader) using round-robin arbitration. It also performs RISC-V sub-word formatting: byte/half/word lane placement, byte enables, sign/zero extension and misalignment detection. It sits between the requesters and a byte-enabled data memory with combinational read.

## Interface
- DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes)
- ADDR_WIDTH, 32, byte address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pN_req_valid  in  1  request valid, N ∈ {0,1}
- pN_req_ready  out  1  request accepted this cycle
- pN_req_addr  in  ADDR_WIDTH  byte address
- pN_req_we  in  1  1 = store, 0 = load
- pN_req_size  in  2  mem_size_t: B=00, H=01, W=10, 11 reserved
- pN_req_unsigned  in  1  zero-extend loads (LBU/LHU)
- pN_req_wdata  in  DATA_WIDTH  store data, right-aligned
- pN_rsp_valid  out  1  one-cycle response pulse
- pN_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- pN_rsp_err  out  1  misaligned or reserved size
- mem_addr  out  ADDR_WIDTH  word-aligned address, with [1:0] = 00
- mem_wdata  out  DATA_WIDTH  lane-shifted store data
- mem_be  out  4  byte-lane write enables
- mem_we  out  1  write strobe
- mem_rdata  in  DATA_WIDTH  combinational read of mem_addr

## Operation
- FSM: IDLE → ACCESS → RESP → IDLE. Reset state is IDLE.
- IDLE:
  - The grant is computed combinationally from the valids.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - The winner's req_ready = 1. A handshake latches the full request and owner, updates last_grant and moves to ACCESS.
  - reset value of last_grant = 1, so p0 wins the first tie.
- ACCESS:
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Store B: be = 0001 << addr[1:0], with wdata[7:0] replicated to all lanes.
  - Store H: be = 0011 << addr[1:0], with wdata[15:0] replicated to both halves.
  - Store W: be = 1111.
  - mem_we = 1 and mem_be as above for stores. For loads, mem_we = 0 and be = 0.
  - Load lanes are taken from mem_rdata >> (8*addr[1:0]) and registered.
  - Next state is RESP.
- Error cases: size H with addr[0] = 1, size W with addr[1:0] ≠ 0, or size 11.
  - The request still passes through ACCESS, but mem_we = 0 and mem_be = 0 (no memory side effect).
  - The error is flagged in RESP with rdata = 0.
- Load extension: B and H are sign-extended from bit 7/15 unless unsigned = 1. W is passed through.
- RESP: the owner's rsp_valid = 1 for exactly one cycle, with rdata and err. Responses have no backpressure. Next state is IDLE.
- req_ready is 0 in ACCESS and RESP.
- Requester rules:
  - A requester holds its request fields stable while valid && !ready.
  - valid must not depend on ready.
  - The non-granted requester keeps waiting.
- Reset values: all outputs are 0, including mem_* and every ready/rsp signal.

## Timing
- Handshake in cycle N → memory access in cycle N+1 → rsp_valid in cycle N+2 → next accept possible in cycle N+3.
- Maximum throughput is one access per 3 cycles.
- Store commit happens at the rising edge that ends ACCESS.
- Read data from mem_rdata is sampled at the end of ACCESS.
- Fairness: under continuous dual requests, grants alternate p0, p1, p0, … Worst-case wait is 3 cycles after the other port's accept.
- Asynchronous rst in ACCESS or RESP:
  - All outputs clear immediately and the FSM returns to IDLE.
  - The in-flight request is dropped and no response is issued.
  - A store in ACCESS is not committed if rst is asserted before the edge.

## Structure
- Package dmem_pkg holds:
  - mem_size_t enum (SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD)
  - arb_state_t (IDLE, ACCESS, RESP)
  - the req_t struct (addr, we, size, unsigned, wdata)
- Sub-module lsu_align (combinational) contains the store lane replication, byte-enable generation, misalignment check and load extract/extend. dmem_arbiter holds the FSM, grant logic and registers.

## Test plan
- Single p0 store W 0xDEADBEEF @0x100, then load W @0x100 → mem_be = 1111, and on the load, rsp_rdata = 0xDEADBEEF with err = 0, rsp at N+2.
- p0 store B 0x80 @0x103, then load B signed @0x103 → be = 1000 and rdata = 0xFFFFFF80. Load B unsigned → 0x00000080.
- Store H 0xABCD @0x202 → be = 1100, word becomes 0xABCDxxxx. Load H signed @0x202 → 0xFFFFABCD.
- Load W @0x101 and store H @0x103 → err = 1, rdata = 0, mem_we = 0 and be = 0, memory unchanged.
- Both ports valid continuously from reset → accepts go p0, p1, p0, p1 at 3-cycle spacing. Each rsp_valid is seen only on its owner's port.
- rst asserted during ACCESS of a store W 0x12345678 @0x300 → no response, and a later load @0x300 returns the prior value.
